// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl: iterative AES-128 encryption sequencer.
// Accepts a plaintext/key pair, applies the initial AddRoundKey, then runs one
// round per clock (rounds 1..9 full, round 10 without MixColumns). The round
// key is derived on the fly from the previous one.
// Optional feature macro: AES_ENC_CTRL_BACK_TO_BACK_EN lets a new pair be
// accepted on the same edge the finished ciphertext is handed off.

module aes_enc_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] state_out,
    output logic [3:0]   round,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic         load;

    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;

    logic [127:0] next_key;
    logic [127:0] sb_out;
    logic [127:0] sr_out;
    logic [127:0] mc_out;
    logic [127:0] ark_in;
    logic [127:0] round_out;
    logic [7:0]   rcon_next;
    logic         final_round;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_rot;
    logic [31:0]  nw0, nw1, nw2, nw3;

    // Key schedule step: words of the current round key, most significant first.
    assign w0     = key_q[127:96];
    assign w1     = key_q[95:64];
    assign w2     = key_q[63:32];
    assign w3     = key_q[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_sbox u_sbox (
            .data_in  (rot_w3[8*i +: 8]),
            .data_out (sub_rot[8*i +: 8])
        );
    end

    assign nw0      = w0 ^ sub_rot ^ {rcon_q, 24'h000000};
    assign nw1      = w1 ^ nw0;
    assign nw2      = w2 ^ nw1;
    assign nw3      = w3 ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // Round datapath; the last round skips MixColumns.
    aes_sub_bytes u_sub_bytes (
        .data_in  (state_q),
        .data_out (sb_out)
    );

    aes_shift_rows u_shift_rows (
        .data_in  (sb_out),
        .data_out (sr_out)
    );

    aes_mix_columns u_mix_columns (
        .data_in  (sr_out),
        .data_out (mc_out)
    );

    assign final_round = (round_q == 4'd10);
    assign ark_in      = final_round ? sr_out : mc_out;

    aes_add_round_key u_add_round_key (
        .data_in   (ark_in),
        .round_key (next_key),
        .data_out  (round_out)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        fsm_d     = fsm_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load  = 1'b1;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (final_round) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef AES_ENC_CTRL_BACK_TO_BACK_EN
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load  = 1'b1;
                        fsm_d = ROUND;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
`else
                if (out_ready) begin
                    fsm_d = IDLE;
                end
`endif
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State, key, Rcon and round counter: load on accept, advance each round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
        end else if (load) begin
            state_q <= plaintext ^ key;
            key_q   <= key;
            rcon_q  <= 8'h01;
            round_q <= 4'd1;
        end else if (fsm_q == ROUND) begin
            state_q <= round_out;
            key_q   <= next_key;
            rcon_q  <= rcon_next;
            round_q <= final_round ? 4'd10 : round_q + 4'd1;
        end else if (fsm_q == DONE && out_ready) begin
            round_q <= 4'd0;
        end
    end

    assign ciphertext = state_q;
    assign state_out  = state_q;
    assign round      = round_q;

endmodule

// aes_sbox: forward AES S-box, one byte. Table row r holds entries 16r..16r+15.
module aes_sbox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] msb;

    assign msb      = 11'd2047 - {data_in, 3'b000};
    assign data_out = SBOX_TABLE[msb -: 8];

endmodule

// aes_sub_bytes: byte-wise S-box over the whole state.
module aes_sub_bytes (
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        aes_sbox u_sbox (
            .data_in  (data_in[8*i +: 8]),
            .data_out (data_out[8*i +: 8])
        );
    end

endmodule

// aes_shift_rows: row r rotates left by r. Byte 4c+r is row r, column c.
module aes_shift_rows (
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign data_out[127-8*(4*c+r) -: 8] = data_in[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

endmodule

// aes_mix_columns: multiply each column by the fixed {02,03,01,01} circulant.
module aes_mix_columns (
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_in[127-32*c -: 8];
        assign a1 = data_in[119-32*c -: 8];
        assign a2 = data_in[111-32*c -: 8];
        assign a3 = data_in[103-32*c -: 8];
        assign data_out[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign data_out[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign data_out[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign data_out[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// aes_add_round_key: XOR the state with the round key.
module aes_add_round_key (
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    output logic [127:0] data_out
);

    assign data_out = data_in ^ round_key;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb_aes_enc_ctrl: directed and random checks of aes_enc_ctrl against a
// byte-array AES-128 reference model (S-box derived from GF(2^8) inversion,
// full key expansion up front) plus the FIPS-197 known-answer vectors.

module tb_aes_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic [127:0] state_out;
    logic [3:0]   round;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_state [11];

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_R1  = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_enc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (pt_in),
        .key        (key_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .state_out  (state_out),
        .round      (round),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] m_sub(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_tab[get_byte(v, i)];
        return o;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] v);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = get_byte(v, 4*((c+r)%4)+r);
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = get_byte(v, 4*c+r);
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                                        ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    // Fill exp_state[k] with the state after round k (k=0 is the initial AddRoundKey).
    task automatic model(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        exp_state[0] = s;
        for (int r = 1; r <= 10; r++) begin
            s = m_shift(m_sub(s));
            if (r < 10) s = m_mix(s);
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            exp_state[r] = s;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair and return just after the accept edge.
    task automatic offer(input logic [127:0] pt, input logic [127:0] k);
        int n = 0;
        while (in_ready !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("in_ready_wait", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        pt_in    = pt;
        key_in   = k;
        step();
        in_valid = 1'b0;
        pt_in    = {$urandom, $urandom, $urandom, $urandom};
        key_in   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Follow the ten rounds after accept, checking every intermediate state.
    task automatic run_rounds(input string tag);
        check({tag, "_s0"}, state_out, exp_state[0]);
        check({tag, "_rnd0"}, 128'(round), 128'd1);
        check({tag, "_busy"}, 128'(busy), 128'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("%s_s%0d", tag, k), state_out, exp_state[k]);
            check($sformatf("%s_rnd%0d", tag, k), 128'(round), 128'(k < 10 ? k + 1 : 10));
        end
        check({tag, "_out_valid"}, 128'(out_valid), 128'd1);
        check({tag, "_ct"}, ciphertext, exp_state[10]);
    endtask

    // Hold out_ready low for n cycles, then hand off in one cycle.
    task automatic handoff(input string tag, input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = i[0];
            pt_in    = {$urandom, $urandom, $urandom, $urandom};
            check({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
            check({tag, "_hold_ready"}, 128'(in_ready), 128'd0);
            check({tag, "_hold_ct"}, ciphertext, exp_state[10]);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_pre_valid"}, 128'(out_valid), 128'd1);
        step();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_post_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_post_round"}, 128'(round), 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt_in     = '0;
        key_in    = '0;
        build_sbox();

        // Reset state.
        step();
        step();
        rst = 1'b0;
        check("rst_round", 128'(round), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_state", state_out, 128'd0);

        // FIPS-197 C.1 with round-by-round tracking (covers Rcon 80 -> 1b -> 36).
        model(C1_PT, C1_KEY);
        offer(C1_PT, C1_KEY);
        check("c1_model_sanity_ct", exp_state[10], C1_CT);
        run_rounds("c1");
        check("c1_ct_const", ciphertext, C1_CT);

        // Backpressure: five cycles with out_ready low and in_valid pulses.
        handoff("bp", 5);

        // After E1 of a fresh C.1 run, state and round match the published values.
        offer(C1_PT, C1_KEY);
        step();
        check("c1_e1_state", state_out, C1_R1);
        check("c1_e1_round", 128'(round), 128'd2);
        repeat (9) step();
        check("c1_e10_ct", ciphertext, C1_CT);
        handoff("c1b", 0);

        // FIPS-197 appendix B with out_ready held high: out_valid lasts one cycle.
        model(B_PT, B_KEY);
        offer(B_PT, B_KEY);
        out_ready = 1'b1;
        run_rounds("b");
        check("b_ct_const", ciphertext, B_CT);
        step();
        check("b_one_cycle_valid", 128'(out_valid), 128'd0);
        check("b_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b0;

        // Reset in the middle of a block while in_valid is high.
        offer({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        repeat (4) step();
        check("mid_round5", 128'(round), 128'd5);
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        check("mid_rst_round", 128'(round), 128'd0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_state", state_out, 128'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        model(C1_PT, C1_KEY);
        offer(C1_PT, C1_KEY);
        run_rounds("post_rst");

        // Present B while C.1 hands off.
        in_valid  = 1'b1;
        pt_in     = B_PT;
        key_in    = B_KEY;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        model(B_PT, B_KEY);
`ifdef AES_ENC_CTRL_BACK_TO_BACK_EN
        in_valid = 1'b0;
        run_rounds("b2b");
`else
        check("b2b_handoff_round", 128'(round), 128'd0);
        check("b2b_handoff_ready", 128'(in_ready), 128'd1);
        check("b2b_handoff_busy", 128'(busy), 128'd0);
        step();
        in_valid = 1'b0;
        run_rounds("b2b");
`endif
        check("b2b_ct_const", ciphertext, B_CT);
        handoff("b2b", 1);

        // Random pairs against the reference model with random handoff delay.
        for (int t = 0; t < 4; t++) begin
            logic [127:0] rp;
            logic [127:0] rk;
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            model(rp, rk);
            offer(rp, rk);
            run_rounds($sformatf("rnd%0d", t));
            handoff($sformatf("rnd%0d", t), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
